acc_requant: RTL and testbench

ACC_REQUANT -- requirements
Module: acc_requant

---
 rtl/acc_requant.sv | 143 ++++++++++++++
 tb/tb_acc_requant.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant.sv
// acc_requant -- two-stage requantizer for wide MAC accumulator sums.
//
// Turns a signed accumulator with QN+WN fraction bits into a signed activation
// with QN fraction bits. Stage 1 rounds half-up (arithmetic shift by WN).
// Stage 2 saturates to OW bits and holds the output register. Both stages
// carry a valid bit and use a ready/valid handshake, so the pipeline can stall.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   acc_valid  accumulator sum offered
//   acc_ready  block accepts acc_data this cycle
//   acc_data   [AW-1:0] signed accumulator, QN+WN fraction bits
//   out_valid  requantized activation available
//   out_ready  downstream accepts out_data
//   out_data   [OW-1:0] signed activation, QN fraction bits
//   sat_clr    synchronous clear of the saturation status
//   sat_flag   sticky flag: at least one output was clamped
//   sat_cnt    [15:0] count of clamped outputs; holds at 16'hFFFF
//
// Build option:
//   ACC_REQUANT_RELU_EN  when defined, a negative stage-2 result becomes 0
//                        after saturation. A negative clamp still counts as
//                        a saturation event.

module acc_requant #(
  parameter int N  = 2,   // accumulator guard bits
  parameter int QM = 12,  // activation integer bits
  parameter int QN = 20,  // activation fraction bits
  parameter int WM = 6,   // weight integer bits
  parameter int WN = 10,  // weight fraction bits
  localparam int AW = QM + QN + WM + WN + N,
  localparam int OW = QM + QN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_valid,
  output logic          acc_ready,
  input  logic [AW-1:0] acc_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  input  logic          sat_clr,
  output logic          sat_flag,
  output logic [15:0]   sat_cnt
);

  // Width of the rounded value: the AW+1-bit sum shifted right by WN.
  localparam int RW = AW + 1 - WN;
  localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (WN - 1);

  logic                 s1_valid;
  logic signed [RW-1:0] s1_r;
  logic                 s2_valid;
  logic [OW-1:0]        s2_data;

  logic                 s2_adv;
  logic                 in_fire;
  logic signed [AW:0]   sum;
  logic signed [RW-1:0] r_in;
  logic [RW-OW:0]       top;
  logic                 sat_pos;
  logic                 sat_neg;
  logic [OW-1:0]        sat_val;

  // S2 can take a new value when empty or when its value leaves this cycle.
  // S1 moves exactly when S2 can take it, so acc_ready depends on out_ready
  // only through s2_adv.
  assign s2_adv    = !s2_valid || out_ready;
  assign acc_ready = !s1_valid || s2_adv;
  assign in_fire   = acc_valid && acc_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  // Stage 1 rounding. The sum is one bit wider than acc_data, so adding the
  // half-LSB can never overflow.
  always_comb begin
    sum  = $signed({acc_data[AW-1], acc_data}) + HALF;
    r_in = RW'(sum >>> WN);
  end

  // Stage 2 saturation. The value fits in OW bits only when every bit from
  // the sign down to bit OW-1 is identical.
  always_comb begin
    top     = s1_r[RW-1:OW-1];
    sat_pos = !s1_r[RW-1] && (|top);
    sat_neg =  s1_r[RW-1] && !(&top);
    if (sat_pos) begin
      sat_val = {1'b0, {(OW-1){1'b1}}};
    end else if (sat_neg) begin
      sat_val = {1'b1, {(OW-1){1'b0}}};
    end else begin
      sat_val = s1_r[OW-1:0];
    end
`ifdef ACC_REQUANT_RELU_EN
    if (sat_val[OW-1]) begin
      sat_val = '0;
    end
`else
`endif
  end

  // NOTE: s1_r is a pure data register. s1_valid qualifies it, so it needs no
  // reset. It loads only on an accepted transfer, so acc_data is never
  // sampled while acc_valid is low.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_r <= r_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      sat_flag <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      if (acc_ready) begin
        s1_valid <= acc_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= sat_val;
        end
      end
      // If a clear and a clamp happen in the same cycle, the clear wins.
      if (sat_clr) begin
        sat_flag <= 1'b0;
        sat_cnt  <= '0;
      end else if (s2_adv && s1_valid && (sat_pos || sat_neg)) begin
        sat_flag <= 1'b1;
        if (sat_cnt != 16'hFFFF) begin
          sat_cnt <= sat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Testbench for acc_requant with default parameters (AW=50, OW=32, WN=10).
// Expected outputs come from an arithmetic reference model. They are queued
// when an input transfer happens. A monitor on the falling edge pops the queue
// and compares each output handshake against it.

module tb_acc_requant;

  localparam int AW = 50;
  localparam int OW = 32;
  localparam int WN = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          acc_valid = 1'b0;
  logic          acc_ready;
  logic [AW-1:0] acc_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          sat_clr = 1'b0;
  logic          sat_flag;
  logic [15:0]   sat_cnt;

  acc_requant dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_clr   (sat_clr),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: round half-up to QN fraction bits, clamp to OW bits.
  function automatic logic [OW-1:0] model(input logic signed [AW-1:0] a, output bit clamped);
    longint v, r, res;
    longint hi, lo;
    v  = a;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    r  = (v + (longint'(1) <<< (WN - 1))) >>> WN;
    clamped = 1'b0;
    if (r > hi) begin
      res = hi; clamped = 1'b1;
    end else if (r < lo) begin
      res = lo; clamped = 1'b1;
    end else begin
      res = r;
    end
`ifdef ACC_REQUANT_RELU_EN
    if (res < 0) res = 0;
`endif
    return res[OW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    logic [63:0] raw;
    longint v;
    raw = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = $signed(raw[21:0]);
      1: begin
        v = (longint'(1) <<< 41) - 2048 + longint'(raw[11:0]);
        if (raw[63]) v = -v;
      end
      2: v = $signed(raw[AW-1:0]);
      default: v = (longint'($signed(raw[20:0])) <<< 10) + 511 + longint'(raw[40:39]);
    endcase
    return v[AW-1:0];
  endfunction

  // Scoreboard state
  logic [OW-1:0] exp_q[$];
  int            cyc_q[$];
  logic [OW-1:0] cur_exp = '0;
  bit            cur_clamp = 1'b0;
  int            sat_model = 0;
  int            cyc = 0;
  bit            lat_check = 1'b0;
  int            rdy_mode = 0;
  int            pidx = 0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  int            inflight;
  logic [3:0]    pat = 4'b1001;

  always @(posedge clk) cyc++;

  // out_ready driver: 0 = held high, 1 = cyclic 1,0,0,1 pattern, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: inputs are stable at the falling edge, so each handshake seen
  // here is the transfer that happens on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      inflight = exp_q.size();
      // Both slots full (two samples in flight) and downstream stalled is
      // the only case that may block the input.
      check("acc_ready_rule", 64'(acc_ready), 64'(!(inflight == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (lat_check && acc_valid) check("b2b_accept", 64'(acc_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_data), 64'hDEAD);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          if (lat_check) check("latency", 64'(cyc - cyc_q.pop_front()), 64'd2);
          else void'(cyc_q.pop_front());
        end
      end
      if (acc_valid && acc_ready) begin
        exp_q.push_back(cur_exp);
        cyc_q.push_back(cyc);
        if (cur_clamp && sat_model < 65535) sat_model++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Offer one sample; return one clock after it is accepted.
  task automatic send(input logic [AW-1:0] a, input logic [OW-1:0] e, input bit cl);
    int guard;
    guard     = 0;
    acc_valid = 1'b1;
    acc_data  = a;
    cur_exp   = e;
    cur_clamp = cl;
    @(negedge clk);
    while (!acc_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!acc_ready) check("accept_timeout", 64'(guard), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    logic [AW-1:0] a;
    logic [OW-1:0] e;
    bit cl;
    a = rand_acc();
    e = model(a, cl);
    send(a, e, cl);
  endtask

  task automatic idle();
    acc_valid = 1'b0;
    acc_data  = 'x;
  endtask

  task automatic drain();
    int g;
    g = 0;
    idle();
    rdy_mode = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
    check("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [OW-1:0] e;
    bit cl;

    // Power-on reset
    idle();
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    #20 rst = 1'b0;
    @(negedge clk);
    check("rst_acc_ready", 64'(acc_ready), 64'd1);
    @(posedge clk); #1;

    // Rounding vectors, sent back to back
    lat_check = 1'b1;
    send(AW'(1024), OW'(1), 1'b0);
    send(AW'(512), OW'(1), 1'b0);
    send(AW'(-512), OW'(0), 1'b0);
    send(AW'(-513), OW'(-1), 1'b0);
    send(AW'(1535), OW'(1), 1'b0);
    drain();
    lat_check = 1'b0;
    check("round_sat_flag", 64'(sat_flag), 64'd0);
    check("round_sat_cnt", 64'(sat_cnt), 64'd0);

    // Positive and negative saturation
    @(posedge clk); #1;
    send(AW'(64'sd1 <<< 41), 32'h7FFF_FFFF, 1'b1);
`ifdef ACC_REQUANT_RELU_EN
    send(AW'(-(64'sd1 <<< 41) - 1024), 32'h0000_0000, 1'b1);
`else
    send(AW'(-(64'sd1 <<< 41) - 1024), 32'h8000_0000, 1'b1);
`endif
    drain();
    check("sat_cnt_two", 64'(sat_cnt), 64'd2);
    check("sat_flag_set", 64'(sat_flag), 64'd1);

    // Throughput: 8 back-to-back random samples with out_ready held high
    @(posedge clk); #1;
    lat_check = 1'b1;
    for (int i = 0; i < 8; i++) send_rand();
    drain();
    lat_check = 1'b0;

    // Backpressure: 1,0,0,1 pattern, then random out_ready
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      rdy_mode = (i < 50) ? 1 : 2;
      send_rand();
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    drain();
    check("bp_sat_cnt", 64'(sat_cnt), 64'(sat_model));
    check("bp_sat_flag", 64'(sat_flag), 64'(sat_model != 0));

    // sat_clr in the same cycle that a clamped sample enters stage 2
    check("pre_clr_flag", 64'(sat_flag), 64'd1);
    @(posedge clk); #1;
    send(AW'(64'sd1 <<< 41), 32'h7FFF_FFFF, 1'b0);
    idle();
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    sat_model = 0;
    check("clr_sat_flag", 64'(sat_flag), 64'd0);
    check("clr_sat_cnt", 64'(sat_cnt), 64'd0);
    drain();
    @(posedge clk); #1;
    a = AW'(-(64'sd1 <<< 45));
    e = model(a, cl);
    send(a, e, cl);
    drain();
    check("post_clr_sat_cnt", 64'(sat_cnt), 64'd1);

    // Reset between clock edges with two samples in flight
    @(posedge clk); #1;
    send(AW'(64'sd1 <<< 41), 32'h7FFF_FFFF, 1'b1);
    send_rand();
    idle();
    #2;
    rst = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    sat_model = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_sat_flag", 64'(sat_flag), 64'd0);
    check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    #13 rst = 1'b0;
    @(negedge clk);
    check("midrst_acc_ready", 64'(acc_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_output", 64'(out_valid), 64'd0);
    end

    // Normal operation resumes after reset
    @(posedge clk); #1;
    lat_check = 1'b1;
    for (int i = 0; i < 4; i++) send_rand();
    drain();
    lat_check = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
